// File: rtl/spi_pkg.sv
// Shared definitions for the SPI mode-0 master: FSM states, byte width and
// default clock divider.
package spi_pkg;

  localparam int SPI_BYTE_BITS       = 8;
  localparam int HALF_PERIOD_DEFAULT = 10;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SHIFT_LOW,
    SHIFT_HIGH,
    HOLD,
    CS_TRAIL,
    CS_DESELECT
  } spi_state_t;

endpackage

// File: rtl/spi_half_period_timer.sv
// Reload/expire counter: o_tick is high in the HALF_PERIOD-th cycle after a
// reload, then the count restarts on its own.
module spi_half_period_timer
  import spi_pkg::*;
#(
  parameter int HALF_PERIOD = HALF_PERIOD_DEFAULT,
  parameter int CNT_W       = $clog2(HALF_PERIOD + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic i_reload,
  output logic o_tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF_PERIOD - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_reload || o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master for the PmodACL2 link: one MSB-first byte per start,
// with an optional chip-select hold so several bytes share one frame.
module spi_master
  import spi_pkg::*;
#(
  parameter int HALF_PERIOD = HALF_PERIOD_DEFAULT,
  parameter int CNT_W       = $clog2(HALF_PERIOD + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [SPI_BYTE_BITS-1:0] tx_data,
  input  logic                     keep_cs,
  input  logic                     cs_release,
  output logic                     busy,
  output logic                     done,
  output logic [SPI_BYTE_BITS-1:0] rx_data,
  output logic                     sclk_o,
  output logic                     ncs_o,
  output logic                     mosi_o,
  input  logic                     miso_i
);

  localparam logic [2:0] LAST_BIT = 3'(SPI_BYTE_BITS - 1);

  spi_state_t               r_state, w_state_next;
  logic [SPI_BYTE_BITS-1:0] r_tx_shift, w_tx_shift_next;
  logic [SPI_BYTE_BITS-1:0] r_rx_shift, w_rx_shift_next;
  logic [SPI_BYTE_BITS-1:0] r_rx_data, w_rx_data_next;
  logic [2:0]               r_bit_cnt, w_bit_cnt_next;
  logic                     r_keep_cs, w_keep_cs_next;
  logic                     r_busy, w_busy_next;
  logic                     r_done, w_done_next;
  logic                     r_sclk, w_sclk_next;
  logic                     r_ncs, w_ncs_next;
  logic                     r_mosi, w_mosi_next;
  logic                     w_tick;
  logic                     w_reload;

  // Every state change restarts the half-period count.
  assign w_reload = (w_state_next != r_state);

  spi_half_period_timer #(
    .HALF_PERIOD(HALF_PERIOD),
    .CNT_W      (CNT_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .i_reload(w_reload),
    .o_tick  (w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_tx_shift <= '0;
      r_rx_shift <= '0;
      r_rx_data  <= '0;
      r_bit_cnt  <= '0;
      r_keep_cs  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_sclk     <= 1'b0;
      r_ncs      <= 1'b1;
      r_mosi     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_tx_shift <= w_tx_shift_next;
      r_rx_shift <= w_rx_shift_next;
      r_rx_data  <= w_rx_data_next;
      r_bit_cnt  <= w_bit_cnt_next;
      r_keep_cs  <= w_keep_cs_next;
      r_busy     <= w_busy_next;
      r_done     <= w_done_next;
      r_sclk     <= w_sclk_next;
      r_ncs      <= w_ncs_next;
      r_mosi     <= w_mosi_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_tx_shift_next = r_tx_shift;
    w_rx_shift_next = r_rx_shift;
    w_rx_data_next  = r_rx_data;
    w_bit_cnt_next  = r_bit_cnt;
    w_keep_cs_next  = r_keep_cs;
    w_busy_next     = r_busy;
    w_done_next     = 1'b0;
    w_sclk_next     = r_sclk;
    w_ncs_next      = r_ncs;
    w_mosi_next     = r_mosi;

    case (r_state)
      IDLE: begin
        if (start) begin
          w_tx_shift_next = tx_data;
          w_keep_cs_next  = keep_cs;
          w_bit_cnt_next  = '0;
          w_ncs_next      = 1'b0;
          w_busy_next     = 1'b1;
          w_mosi_next     = tx_data[SPI_BYTE_BITS-1];
          w_state_next    = CS_SETUP;
        end
      end

      CS_SETUP: begin
        if (w_tick) begin
          w_state_next = SHIFT_LOW;
        end
      end

      SHIFT_LOW: begin
        // miso_i is captured on the same edge that raises sclk_o.
        if (w_tick) begin
          w_sclk_next     = 1'b1;
          w_rx_shift_next = {r_rx_shift[SPI_BYTE_BITS-2:0], miso_i};
          w_state_next    = SHIFT_HIGH;
        end
      end

      SHIFT_HIGH: begin
        if (w_tick) begin
          w_sclk_next    = 1'b0;
          w_bit_cnt_next = r_bit_cnt + 3'd1;
          if (r_bit_cnt != LAST_BIT) begin
            w_tx_shift_next = {r_tx_shift[SPI_BYTE_BITS-2:0], 1'b0};
            w_mosi_next     = r_tx_shift[SPI_BYTE_BITS-2];
            w_state_next    = SHIFT_LOW;
          end else begin
            w_rx_data_next = r_rx_shift;
            w_done_next    = 1'b1;
            if (r_keep_cs) begin
              w_busy_next  = 1'b0;
              w_state_next = HOLD;
            end else begin
              w_state_next = CS_TRAIL;
            end
          end
        end
      end

      HOLD: begin
        // A chained byte skips the setup phase; start beats cs_release.
        if (start) begin
          w_tx_shift_next = tx_data;
          w_keep_cs_next  = keep_cs;
          w_bit_cnt_next  = '0;
          w_busy_next     = 1'b1;
          w_mosi_next     = tx_data[SPI_BYTE_BITS-1];
          w_state_next    = SHIFT_LOW;
        end else if (cs_release) begin
          w_busy_next  = 1'b1;
          w_state_next = CS_TRAIL;
        end
      end

      CS_TRAIL: begin
        if (w_tick) begin
          w_ncs_next   = 1'b1;
          w_state_next = CS_DESELECT;
        end
      end

      CS_DESELECT: begin
        if (w_tick) begin
          w_busy_next  = 1'b0;
          w_state_next = IDLE;
        end
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign rx_data = r_rx_data;
  assign sclk_o  = r_sclk;
  assign ncs_o   = r_ncs;
  assign mosi_o  = r_mosi;

endmodule

// File: tb/tb_spi_master.sv
// Directed plus randomized checks of spi_master against a byte-level slave
// model and cycle-latency rules derived from the half period.
module tb_spi_master;

  localparam int HP = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] tx_data;
  logic       keep_cs;
  logic       cs_release;
  logic       busy;
  logic       done;
  logic [7:0] rx_data;
  logic       sclk_o;
  logic       ncs_o;
  logic       mosi_o;
  logic       miso_i;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int acc_cyc  = 0;
  int ref_cyc  = 0;
  int rise_cnt = 0;
  int done_cnt = 0;
  int ncs_rise_cnt = 0;

  logic [7:0] mosi_cap = 8'h00;
  logic [7:0] s_out    = 8'h00;
  int         s_idx    = 0;
  logic [7:0] slave_q[$];

  always #5 clk = ~clk;

  spi_master #(.HALF_PERIOD(HP)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .tx_data   (tx_data),
    .keep_cs   (keep_cs),
    .cs_release(cs_release),
    .busy      (busy),
    .done      (done),
    .rx_data   (rx_data),
    .sclk_o    (sclk_o),
    .ncs_o     (ncs_o),
    .mosi_o    (mosi_o),
    .miso_i    (miso_i)
  );

  // Mode-0 slave: presents its byte MSB first from the chip-select fall,
  // advances on each falling sclk, loads the next queued byte after eight bits.
  assign miso_i = s_out[7];

  always @(negedge ncs_o) begin
    s_idx = 0;
    if (slave_q.size() > 0) s_out = slave_q.pop_front();
    else s_out = 8'h00;
  end

  always @(negedge sclk_o) begin
    if (ncs_o === 1'b0) begin
      if (s_idx == 7) begin
        s_idx = 0;
        if (slave_q.size() > 0) s_out = slave_q.pop_front();
        else s_out = 8'h00;
      end else begin
        s_idx = s_idx + 1;
        s_out = {s_out[6:0], 1'b0};
      end
    end
  end

  always @(posedge sclk_o) begin
    mosi_cap = {mosi_cap[6:0], mosi_o};
    rise_cnt = rise_cnt + 1;
  end

  always @(posedge ncs_o) ncs_rise_cnt = ncs_rise_cnt + 1;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (done === 1'b1) done_cnt = done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input logic [7:0] tx, input logic keep, input logic rel);
    @(negedge clk);
    tx_data    = tx;
    keep_cs    = keep;
    cs_release = rel;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    cs_release = 1'b0;
    acc_cyc    = cyc;
  endtask

  task automatic wait_done(output int lat);
    int g = 0;
    while (done !== 1'b1 && g < 400) begin
      @(negedge clk);
      g++;
    end
    lat     = cyc - acc_cyc;
    ref_cyc = cyc;
  endtask

  task automatic wait_ncs_high(output int d);
    int g = 0;
    while (ncs_o !== 1'b1 && g < 400) begin
      @(negedge clk);
      g++;
    end
    d = cyc - ref_cyc;
  endtask

  task automatic wait_not_busy(output int d);
    int g = 0;
    while (busy !== 1'b0 && g < 400) begin
      @(negedge clk);
      g++;
    end
    d = cyc - ref_cyc;
  endtask

  task automatic run_byte(input string tag, input logic [7:0] tx, input logic keep,
                          input logic rel, input int exp_lat, input logic [7:0] exp_rx);
    int lat;
    mosi_cap = 8'h00;
    rise_cnt = 0;
    pulse_start(tx, keep, rel);
    check({tag, ".busy"}, busy, 1);
    wait_done(lat);
    $display("%s: tx=%02h keep=%0d rel=%0d rx=%02h exp_rx=%02h lat=%0d",
             tag, tx, keep, rel, rx_data, exp_rx, lat);
    check({tag, ".lat"}, lat, exp_lat);
    check({tag, ".rx"}, rx_data, exp_rx);
    check({tag, ".mosi"}, mosi_cap, tx);
    check({tag, ".rises"}, rise_cnt, 8);
    check({tag, ".ncs_low"}, ncs_o, 0);
  endtask

  initial begin
    int d;
    int lat;
    int r0;
    int d0;
    int g;
    logic [7:0] tx;
    logic [7:0] sb;
    logic [7:0] sb2;

    rst        = 1'b1;
    start      = 1'b0;
    tx_data    = 8'h00;
    keep_cs    = 1'b0;
    cs_release = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.ncs", ncs_o, 1);
    check("rst.sclk", sclk_o, 0);
    check("rst.mosi", mosi_o, 0);
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.rx", rx_data, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single byte, fresh frame
    slave_q.delete();
    slave_q.push_back(8'h3C);
    r0 = ncs_rise_cnt;
    run_byte("a5", 8'hA5, 1'b0, 1'b0, 17 * HP, 8'h3C);
    wait_ncs_high(d);
    check("a5.ncs_rise", d, HP);
    wait_not_busy(d);
    check("a5.busy_low", d, 2 * HP);
    check("a5.ncs_edges", ncs_rise_cnt - r0, 1);

    // Three-byte chained frame
    tx = 8'($urandom);
    slave_q.delete();
    slave_q.push_back(8'h00);
    slave_q.push_back(8'h00);
    slave_q.push_back(8'hAD);
    r0 = ncs_rise_cnt;
    run_byte("ch0", 8'h0B, 1'b1, 1'b0, 17 * HP, 8'h00);
    check("ch0.hold_busy", busy, 0);
    run_byte("ch1", 8'h00, 1'b1, 1'b0, 16 * HP, 8'h00);
    run_byte("ch2", tx, 1'b0, 1'b0, 16 * HP, 8'hAD);
    check("ch.ncs_held", ncs_rise_cnt - r0, 0);
    wait_ncs_high(d);
    check("ch.ncs_rise", d, HP);
    wait_not_busy(d);
    check("ch.busy_low", d, 2 * HP);

    // start pulsed mid-byte is ignored
    tx = 8'($urandom);
    sb = 8'($urandom);
    slave_q.delete();
    slave_q.push_back(sb);
    d0 = done_cnt;
    mosi_cap = 8'h00;
    rise_cnt = 0;
    pulse_start(tx, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    tx_data = ~tx;
    keep_cs = 1'b1;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    $display("ign: tx=%02h rx=%02h exp_rx=%02h lat=%0d", tx, rx_data, sb, lat);
    check("ign.lat", lat, 17 * HP);
    check("ign.rx", rx_data, sb);
    check("ign.mosi", mosi_cap, tx);
    wait_ncs_high(d);
    check("ign.ncs_rise", d, HP);
    wait_not_busy(d);
    check("ign.busy_low", d, 2 * HP);
    repeat (10 * HP) @(negedge clk);
    check("ign.one_done", done_cnt - d0, 1);
    check("ign.rises", rise_cnt, 8);
    check("ign.idle", busy, 0);

    // HOLD then cs_release
    tx = 8'($urandom);
    sb = 8'($urandom);
    slave_q.delete();
    slave_q.push_back(sb);
    run_byte("hold", tx, 1'b1, 1'b0, 17 * HP, sb);
    repeat (3) @(negedge clk);
    check("hold.ncs", ncs_o, 0);
    rise_cnt = 0;
    @(negedge clk);
    cs_release = 1'b1;
    @(negedge clk);
    cs_release = 1'b0;
    ref_cyc = cyc;
    $display("rel: cs_release accepted at cycle %0d", ref_cyc);
    wait_ncs_high(d);
    check("rel.ncs_rise", d, HP);
    check("rel.no_sclk", rise_cnt, 0);
    wait_not_busy(d);
    check("rel.busy_low", d, 2 * HP);

    // HOLD with start and cs_release together: start wins
    tx  = 8'($urandom);
    sb  = 8'($urandom);
    sb2 = 8'($urandom) | 8'h01;
    slave_q.delete();
    slave_q.push_back(sb);
    slave_q.push_back(sb2);
    run_byte("hs0", tx, 1'b1, 1'b0, 17 * HP, sb);
    r0 = ncs_rise_cnt;
    tx = 8'($urandom);
    run_byte("hs1", tx, 1'b0, 1'b1, 16 * HP, sb2);
    check("hs.ncs_held", ncs_rise_cnt - r0, 0);
    wait_ncs_high(d);
    check("hs.ncs_rise", d, HP);
    wait_not_busy(d);

    // Reset during bit 4
    tx = 8'($urandom) | 8'h08;
    sb = 8'($urandom);
    slave_q.delete();
    slave_q.push_back(sb);
    mosi_cap = 8'h00;
    rise_cnt = 0;
    d0 = done_cnt;
    pulse_start(tx, 1'b0, 1'b0);
    g = 0;
    while (rise_cnt < 5 && g < 400) begin
      @(negedge clk);
      g++;
    end
    check("rstmid.reached", rise_cnt, 5);
    rst = 1'b1;
    @(negedge clk);
    $display("rstmid: tx=%02h reset applied after %0d sclk rises", tx, rise_cnt);
    check("rstmid.ncs", ncs_o, 1);
    check("rstmid.sclk", sclk_o, 0);
    check("rstmid.mosi", mosi_o, 0);
    check("rstmid.busy", busy, 0);
    check("rstmid.rx", rx_data, 0);
    check("rstmid.done", done, 0);
    rst = 1'b0;
    repeat (20 * HP) @(negedge clk);
    check("rstmid.no_done", done_cnt - d0, 0);
    sb = 8'($urandom);
    slave_q.delete();
    slave_q.push_back(sb);
    run_byte("post", 8'h5A, 1'b0, 1'b0, 17 * HP, sb);
    wait_not_busy(d);
    check("post.busy_low", d, 2 * HP);

    // Randomized single-byte frames
    for (int i = 0; i < 4; i++) begin
      tx = 8'($urandom);
      sb = 8'($urandom);
      slave_q.delete();
      slave_q.push_back(sb);
      run_byte("rnd", tx, 1'b0, 1'b0, 17 * HP, sb);
      wait_not_busy(d);
      check("rnd.busy_low", d, 2 * HP);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
